// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Brief    : LSU data-memory responder, fixed-latency doubleword array access.
//            Optional macro DMEM_MISALIGN_CHECK_EN rejects unaligned accesses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [0:63] i_addr,
    input  logic        i_enr,
    input  logic        i_enw,
    input  logic [0:1]  i_size,
    input  logic [0:63] i_wdata,
    output logic [0:63] o_rdata,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_err,
    output logic [0:1]  o_err_code
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [63:0]   r_addr;
    logic [1:0]    r_size;
    logic [63:0]   r_wdata;
    logic          r_wr;
    logic          r_conflict;
    logic [63:0]   r_mem [DEPTH];

    logic               w_idle;
    logic               w_accept;
    logic               w_access;
    logic [63:0]        w_addr;
    logic [1:0]         w_size;
    logic [63:0]        w_wdata;
    logic               w_wr;
    logic               w_conflict;
    logic               w_oor;
    logic               w_misal;
    logic [2:0]         w_lowmask;
    logic [2:0]         w_off;
    logic [5:0]         w_shift;
    logic [63:0]        w_bmask;
    logic [c_IDX_W-1:0] w_idx;
    logic [63:0]        w_dw;
    logic [63:0]        w_rd_val;
    logic [63:0]        w_wr_mask;
    logic [63:0]        w_wr_val;
    logic [1:0]         w_err_code;
    logic [63:0]        w_out_rdata;
    logic               w_mem_we;

    // With LATENCY = 1 the access happens on the acceptance edge, so it is fed
    // straight from the ports; otherwise from the captured request.
    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = w_idle && (i_enr || i_enw);
    assign w_access   = (w_accept && (LATENCY == 1)) || ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_addr     = w_idle ? i_addr : r_addr;
    assign w_size     = w_idle ? i_size : r_size;
    assign w_wdata    = w_idle ? i_wdata : r_wdata;
    assign w_wr       = w_idle ? i_enw : r_wr;
    assign w_conflict = w_idle ? (i_enr && i_enw) : r_conflict;

    always_comb begin
        w_lowmask = 3'b000;
        w_bmask   = 64'h0000_0000_0000_00FF;
        case (w_size)
            2'b01: begin w_lowmask = 3'b001; w_bmask = 64'h0000_0000_0000_FFFF; end
            2'b10: begin w_lowmask = 3'b011; w_bmask = 64'h0000_0000_FFFF_FFFF; end
            2'b11: begin w_lowmask = 3'b111; w_bmask = 64'hFFFF_FFFF_FFFF_FFFF; end
            default: ;
        endcase
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_misal = |(w_addr[2:0] & w_lowmask);
`else
    assign w_misal = 1'b0;
`endif

    // Big-endian lanes: the field's LSB sits (7 - off - (n-1)) bytes up.
    assign w_off       = w_addr[2:0] & ~w_lowmask;
    assign w_shift     = {3'(3'd7 - w_off - w_lowmask), 3'b000};
    assign w_oor       = w_addr[63:3] >= 61'(DEPTH);
    assign w_idx       = w_addr[c_IDX_W+2:3];
    assign w_dw        = r_mem[w_idx];
    assign w_rd_val    = (w_dw >> w_shift) & w_bmask;
    assign w_wr_mask   = w_bmask << w_shift;
    assign w_wr_val    = (w_dw & ~w_wr_mask) | ((w_wdata & w_bmask) << w_shift);

    always_comb begin
        w_err_code = 2'b00;
        if (w_conflict)   w_err_code = 2'b11;
        else if (w_oor)   w_err_code = 2'b10;
        else if (w_misal) w_err_code = 2'b01;
    end

    assign w_out_rdata = ((w_err_code != 2'b00) || w_wr) ? 64'd0 : w_rd_val;
    assign w_mem_we    = w_access && w_wr && (w_err_code == 2'b00) && !i_rst;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_wr_val;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 64'd0;
            r_size     <= 2'b00;
            r_wdata    <= 64'd0;
            r_wr       <= 1'b0;
            r_conflict <= 1'b0;
            o_rdata    <= 64'd0;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= i_addr;
                        r_size     <= i_size;
                        r_wdata    <= i_wdata;
                        r_wr       <= i_enw;
                        r_conflict <= i_enr && i_enw;
                        r_cnt      <= 4'(LATENCY - 1);
                        o_busy     <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state    <= S_DONE;
                            o_valid    <= 1'b1;
                            o_rdata    <= w_out_rdata;
                            o_err      <= |w_err_code;
                            o_err_code <= w_err_code;
                        end else begin
                            r_state    <= S_WAIT;
                            o_err      <= 1'b0;
                            o_err_code <= 2'b00;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state    <= S_DONE;
                        o_valid    <= 1'b1;
                        o_rdata    <= w_out_rdata;
                        o_err      <= |w_err_code;
                        o_err_code <= w_err_code;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios plus randomized
// accesses checked against a byte-addressed reference memory.
`default_nettype none

module tb_data_mem_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addr, wdata, rdata;
    logic        enr, enw, valid, busy, err;
    logic [1:0]  size, err_code;

    logic [63:0] f_addr, f_wdata, f_rdata;
    logic        f_enr, f_enw, f_valid, f_busy, f_err;
    logic [1:0]  f_size, f_err_code;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [8*DEPTH];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_enr(enr), .i_enw(enw),
        .i_size(size), .i_wdata(wdata), .o_rdata(rdata), .o_valid(valid),
        .o_busy(busy), .o_err(err), .o_err_code(err_code)
    );

    data_mem_responder #(.DEPTH(16), .LATENCY(1)) u_fast (
        .i_clk(clk), .i_rst(rst), .i_addr(f_addr), .i_enr(f_enr), .i_enw(f_enw),
        .i_size(f_size), .i_wdata(f_wdata), .o_rdata(f_rdata), .o_valid(f_valid),
        .o_busy(f_busy), .o_err(f_err), .o_err_code(f_err_code)
    );

    // Reference: byte array, n = 2^size bytes, big-endian byte order.
    task automatic model(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [63:0] a, input logic [63:0] wd,
                         output logic [63:0] exp_rdata, output logic [1:0] exp_code);
        int n;
        int base;
        n = 1 << sz;
        exp_rdata = 64'd0;
        exp_code  = 2'b00;
        if (rd && wr) exp_code = 2'b11;
        else if (a >= 64'(8*DEPTH)) exp_code = 2'b10;
`ifdef DMEM_MISALIGN_CHECK_EN
        else if ((a % 64'(n)) != 64'd0) exp_code = 2'b01;
`endif
        else begin
            base = int'(a) - (int'(a) % n);
            for (int i = 0; i < n; i++) begin
                if (wr) ref_mem[base+i] = 8'(wd >> (8*(n-1-i)));
                else    exp_rdata = (exp_rdata << 8) | 64'(ref_mem[base+i]);
            end
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [63:0] a, input logic [63:0] wd,
                         output int lat, output logic [63:0] got_rdata,
                         output logic got_err, output logic [1:0] got_code,
                         output logic err_early);
        @(negedge clk);
        enr = rd; enw = wr; size = sz; addr = a; wdata = wd;
        @(posedge clk);
        lat = 0;
        err_early = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) err_early = err;
        end while (!valid && lat < 20);
        got_rdata = rdata;
        got_err   = err;
        got_code  = err_code;
        enr = 1'b0;
        enw = 1'b0;
    endtask

    task automatic test_reset();
        int lat; logic [63:0] r, e; logic er, ee; logic [1:0] c, ec;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL rst_code: got %b want 00", err_code); end
        n_checks++; if (rdata !== 64'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        rst = 1'b0;
        model(1'b0, 1'b1, 2'b11, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, e, ec);
        drive(1'b0, 1'b1, 2'b11, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, lat, r, er, c, ee);
        // Write abandoned by reset in the middle of WAIT.
        @(negedge clk);
        enw = 1'b1; size = 2'b11; addr = 64'h10; wdata = 64'h1111_2222_3333_4444;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_wait_busy: got %b want 1", busy); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || valid !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: busy %b valid %b err %b want 000", busy, valid, err); end
        enw = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_valid: got %b want 0", valid); end
        rst = 1'b0;
        model(1'b1, 1'b0, 2'b11, 64'h10, 64'd0, e, ec);
        drive(1'b1, 1'b0, 2'b11, 64'h10, 64'd0, lat, r, er, c, ee);
        n_checks++; if (r !== e) begin n_fail++; $display("FAIL rst_prior_data: got %h want %h", r, e); end
    endtask

    task automatic test_roundtrip();
        int lat; logic [63:0] r, e; logic er, ee; logic [1:0] c, ec;
        model(1'b0, 1'b1, 2'b11, 64'h10, 64'h0123_4567_89AB_CDEF, e, ec);
        drive(1'b0, 1'b1, 2'b11, 64'h10, 64'h0123_4567_89AB_CDEF, lat, r, er, c, ee);
        n_checks++; if (lat !== LATENCY) begin n_fail++; $display("FAIL rt_wr_latency: got %0d want %0d", lat, LATENCY); end
        n_checks++; if (er !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rt_wr_flags: err %b busy %b want 0 1", er, busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL rt_release: busy %b valid %b want 0 0", busy, valid); end
        drive(1'b1, 1'b0, 2'b11, 64'h10, 64'd0, lat, r, er, c, ee);
        n_checks++; if (lat !== LATENCY) begin n_fail++; $display("FAIL rt_rd_latency: got %0d want %0d", lat, LATENCY); end
        n_checks++; if (r !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL rt_rd_data: got %h want 0123456789abcdef", r); end
    endtask

    task automatic test_subword();
        logic [63:0] a_tab [3] = '{64'h13, 64'h16, 64'h14};
        logic [1:0]  s_tab [3] = '{2'b00, 2'b01, 2'b10};
        logic [63:0] x_tab [3] = '{64'h67, 64'hCDEF, 64'h89AB_CDEF};
        int lat; logic [63:0] r; logic er, ee; logic [1:0] c;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, s_tab[i], a_tab[i], 64'd0, lat, r, er, c, ee);
            n_checks++; if (r !== x_tab[i] || er !== 1'b0) begin
                n_fail++; $display("FAIL subword_%0d: got %h err %b want %h err 0", i, r, er, x_tab[i]); end
        end
    endtask

    task automatic test_byte_write();
        int lat; logic [63:0] r, e; logic er, ee; logic [1:0] c, ec;
        model(1'b0, 1'b1, 2'b00, 64'h11, 64'hFF, e, ec);
        drive(1'b0, 1'b1, 2'b00, 64'h11, 64'hFF, lat, r, er, c, ee);
        drive(1'b1, 1'b0, 2'b11, 64'h10, 64'd0, lat, r, er, c, ee);
        n_checks++; if (r !== 64'h01FF_4567_89AB_CDEF) begin n_fail++; $display("FAIL byte_write: got %h want 01ff456789abcdef", r); end
    endtask

    task automatic test_errors();
        int lat; logic [63:0] r, e; logic er, ee; logic [1:0] c, ec;
        drive(1'b1, 1'b1, 2'b11, 64'h10, 64'hFFFF, lat, r, er, c, ee);
        n_checks++; if (er !== 1'b1 || c !== 2'b11 || r !== 64'd0) begin
            n_fail++; $display("FAIL err_conflict: err %b code %b rdata %h want 1 11 0", er, c, r); end
        drive(1'b1, 1'b0, 2'b11, 64'(8*DEPTH), 64'd0, lat, r, er, c, ee);
        n_checks++; if (ee !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_accept: got %b want 0", ee); end
        n_checks++; if (er !== 1'b1 || c !== 2'b10 || r !== 64'd0) begin
            n_fail++; $display("FAIL err_range: err %b code %b rdata %h want 1 10 0", er, c, r); end
        // Upper address bits must not alias onto a valid index.
        drive(1'b0, 1'b1, 2'b11, 64'h0000_0100_0000_0010, 64'hBAD0_BAD0_BAD0_BAD0, lat, r, er, c, ee);
        n_checks++; if (c !== 2'b10) begin n_fail++; $display("FAIL err_range_high: code %b want 10", c); end
        model(1'b1, 1'b0, 2'b11, 64'h10, 64'd0, e, ec);
        drive(1'b1, 1'b0, 2'b11, 64'h10, 64'd0, lat, r, er, c, ee);
        n_checks++; if (r !== e) begin n_fail++; $display("FAIL err_range_nowrite: got %h want %h", r, e); end
        model(1'b1, 1'b0, 2'b10, 64'h12, 64'd0, e, ec);
        drive(1'b1, 1'b0, 2'b10, 64'h12, 64'd0, lat, r, er, c, ee);
        n_checks++; if (r !== e || c !== ec || er !== (ec != 2'b00)) begin
            n_fail++; $display("FAIL misalign_read: rdata %h code %b want %h %b", r, c, e, ec); end
        model(1'b0, 1'b1, 2'b10, 64'h12, 64'hAAAA_AAAA, e, ec);
        drive(1'b0, 1'b1, 2'b10, 64'h12, 64'hAAAA_AAAA, lat, r, er, c, ee);
        n_checks++; if (c !== ec) begin n_fail++; $display("FAIL misalign_write_code: got %b want %b", c, ec); end
        model(1'b1, 1'b0, 2'b11, 64'h10, 64'd0, e, ec);
        drive(1'b1, 1'b0, 2'b11, 64'h10, 64'd0, lat, r, er, c, ee);
        n_checks++; if (r !== e) begin n_fail++; $display("FAIL misalign_write_effect: got %h want %h", r, e); end
    endtask

    task automatic test_random();
        int lat; logic [63:0] r, e, a, wd; logic er, ee, rd, wr; logic [1:0] c, ec, sz;
        int sel;
        for (int d = 0; d < DEPTH; d++) begin
            wd = {$urandom, $urandom};
            model(1'b0, 1'b1, 2'b11, 64'(8*d), wd, e, ec);
            drive(1'b0, 1'b1, 2'b11, 64'(8*d), wd, lat, r, er, c, ee);
        end
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 9));
            sz  = 2'($urandom_range(0, 3));
            wd  = {$urandom, $urandom};
            rd  = 1'($urandom_range(0, 1));
            wr  = !rd;
            a   = 64'($urandom_range(0, 8*DEPTH-1));
            if (sel == 0) begin rd = 1'b1; wr = 1'b1; end
            if (sel == 1) a = {$urandom, $urandom} | 64'(8*DEPTH);
            model(rd, wr, sz, a, wd, e, ec);
            drive(rd, wr, sz, a, wd, lat, r, er, c, ee);
            n_checks++;
            if (lat !== LATENCY || c !== ec || er !== (ec != 2'b00) || ((!wr || ec != 2'b00) && r !== e)) begin
                n_fail++;
                $display("FAIL random_%0d: rd %b wr %b size %0d addr %h lat %0d code %b rdata %h want lat %0d code %b rdata %h",
                         i, rd, wr, sz, a, lat, c, r, LATENCY, ec, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        @(negedge clk);
        f_enr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_v = ((i % 2) == 0);
            n_checks++;
            if (f_valid !== exp_v || f_busy !== exp_v) begin
                n_fail++; $display("FAIL b2b_cycle_%0d: valid %b busy %b want %b %b", i, f_valid, f_busy, exp_v, exp_v);
            end
        end
        f_enr = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        enr = 1'b0; enw = 1'b0; size = 2'b00; addr = 64'd0; wdata = 64'd0;
        f_enr = 1'b0; f_enw = 1'b0; f_size = 2'b11; f_addr = 64'd0; f_wdata = 64'd0;
        for (int i = 0; i < 8*DEPTH; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_roundtrip();
        test_subword();
        test_byte_write();
        test_errors();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
